exp_restore_serializer: RTL and testbench
=========================================

Name: exp_restore_serializer

Overview:
Inverse stage of the exponent-subtraction array. It accepts one packed vector of NUM_INPUTS per-lane exponent differences plus the common exp_sum. It adds exp_sum back to each lane and emits the reconstructed MANT_WIDTH-bit values one lane per cycle over a valid/ready stream. It sits between the parallel difference bus and the narrow serial output path of the divider, and flags any lane whose reconstruction does not fit in MANT_WIDTH bits.

Parameters:
NUM_INPUTS, 10, lanes per vector
EXP_WIDTH, 9, width of each difference lane and of exp_sum
MANT_WIDTH, 8, width of the reconstructed output value (MANT_WIDTH < EXP_WIDTH)
IDX_WIDTH, 4, width of the lane index; must satisfy 2^IDX_WIDTH >= NUM_INPUTS

Ports:
clk  input  1  single clock, rising edge
rst  input  1  reset, asynchronous, active-high
in_valid  input  1  vector and exp_sum present
in_ready  output  1  block can capture a vector
exp_sum  input  EXP_WIDTH  common exponent, captured with the vector
exp_bus  input  NUM_INPUTS*EXP_WIDTH  packed differences; lane i at [i*EXP_WIDTH +: EXP_WIDTH]
out_valid  output  1  out_* fields valid
out_ready  input  1  downstream accepts the current beat
out_data  output  MANT_WIDTH  reconstructed lane value
out_index  output  IDX_WIDTH  lane number of the current beat
out_ovf  output  1  current lane overflowed MANT_WIDTH
out_last  output  1  current beat is lane NUM_INPUTS-1
out_err  output  1  sticky OR of out_ovf over the vector; meaningful only when out_last=1
busy  output  1  vector held, not fully drained

Behaviour:
- Reset (async assert, release sync to clk). State=IDLE, idx=0, captured registers=0, sticky error=0. Outputs: in_ready=1, out_valid=0, out_last=0, out_ovf=0, out_err=0, busy=0, out_index=0, out_data=0.
- FSM has two states: IDLE and RUN.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&in_ready at an edge: capture exp_bus and exp_sum, set idx=0, clear sticky error, go to RUN.
  - Inputs are ignored once captured; upstream may change them freely.
- RUN:
  - in_ready=0, out_valid=1, busy=1.
  - The beat for lane idx is presented combinationally from the captured registers.
  - Beat fields are held stable while out_ready=0; stalls are unbounded.
- Arithmetic per lane:
  - s = lane[idx] + exp_sum, computed in EXP_WIDTH bits, wrap modulo 2^EXP_WIDTH.
  - out_data = s[MANT_WIDTH-1:0].
  - out_ovf = |s[EXP_WIDTH-1:MANT_WIDTH].
- Handshake on out_valid&out_ready:
  - The sticky error register ORs in out_ovf.
  - If idx < NUM_INPUTS-1: idx increments and the state stays RUN.
  - If idx == NUM_INPUTS-1: go to IDLE, idx=0.
- out_last = (idx == NUM_INPUTS-1) in RUN.
- out_err = sticky | out_ovf on the last beat; 0 otherwise.
- Latency and throughput:
  - Vector accepted at edge k; lane 0 is valid in the cycle after edge k.
  - With out_ready held high, lanes stream one per cycle and the last beat completes at edge k+NUM_INPUTS.
  - in_ready returns high in the next cycle, giving one idle bubble between vectors. No overlap, no input buffering.
- in_valid asserted in RUN has no effect; upstream holds it until in_ready.
- Reset asserted mid-vector: the vector is discarded immediately, all outputs return to reset values, and no partial beats resume.
- idx never exceeds NUM_INPUTS-1. Values of idx >= NUM_INPUTS are unreachable.

Test Plan:
- Reset, then exp_sum=5, lanes i = (10*i - 5) mod 512 (lane0=0x1FB), out_ready=1 → ten beats out_data=0,10,...,90, out_index=0..9, out_ovf=0, out_last only on index 9, out_err=0. in_ready is low for exactly 10 cycles after acceptance.
- exp_sum=1, lane3=0x0FF, other lanes 0 → beat 3: out_data=0x00, out_ovf=1. Other beats: out_data=0x01, ovf=0. Last beat out_err=1.
- Wrap: exp_sum=0x100, lane0=0x100 → s=0x000, out_data=0, ovf=0. Lane1=0x1FF → s=0x0FF, out_data=0xFF, ovf=0.
- Backpressure: toggle out_ready 1,0,0,1,... → fields hold stable during stalls, no lane skipped or repeated, exactly 10 handshakes. A second in_valid pulse during RUN is ignored.
- Back-to-back vectors: in_valid held high with vector B after vector A → B is captured on the edge after A's last handshake. The sticky error from A (set) does not leak into B (clean).
- Reset asserted while out_index=4 → out_valid drops asynchronously. After release: in_ready=1, busy=0, next vector starts at index 0.

Source files
------------

// File: rtl/exp_restore_serializer.sv
// Adds the common exponent back onto each captured difference lane and streams
// the reconstructed values out one lane per beat, flagging lanes that overflow.

module exp_restore_lane #(
  parameter int EXP_WIDTH  = 9,
  parameter int MANT_WIDTH = 8
) (
  input  logic [EXP_WIDTH-1:0]  diff_i,
  input  logic [EXP_WIDTH-1:0]  sum_i,
  output logic [MANT_WIDTH-1:0] data_o,
  output logic                  ovf_o
);
  logic [EXP_WIDTH-1:0] s;
  assign s      = diff_i + sum_i;
  assign data_o = s[MANT_WIDTH-1:0];
  assign ovf_o  = |s[EXP_WIDTH-1:MANT_WIDTH];
endmodule

module exp_restore_serializer #(
  parameter int NUM_INPUTS = 10,
  parameter int EXP_WIDTH  = 9,
  parameter int MANT_WIDTH = 8,
  parameter int IDX_WIDTH  = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [EXP_WIDTH-1:0]            exp_sum,
  input  logic [NUM_INPUTS*EXP_WIDTH-1:0] exp_bus,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [MANT_WIDTH-1:0]           out_data,
  output logic [IDX_WIDTH-1:0]            out_index,
  output logic                            out_ovf,
  output logic                            out_last,
  output logic                            out_err,
  output logic                            busy
);
  typedef enum logic {IDLE, RUN} state_t;

  state_t                          state_q;
  logic [IDX_WIDTH-1:0]            idx_q, idx_d;
  logic [NUM_INPUTS*EXP_WIDTH-1:0] bus_q;
  logic [EXP_WIDTH-1:0]            sum_q;
  logic                            err_q, err_d;

  logic [NUM_INPUTS-1:0][MANT_WIDTH-1:0] lane_data;
  logic [NUM_INPUTS-1:0]                 lane_ovf;
  logic [MANT_WIDTH-1:0]                 cur_data;
  logic                                  cur_ovf, run, last;

  for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_lane
    exp_restore_lane #(.EXP_WIDTH(EXP_WIDTH), .MANT_WIDTH(MANT_WIDTH)) u_lane (
      .diff_i (bus_q[g*EXP_WIDTH +: EXP_WIDTH]),
      .sum_i  (sum_q),
      .data_o (lane_data[g]),
      .ovf_o  (lane_ovf[g])
    );
  end

  // Explicit compare-mux keeps unreachable idx codes from indexing past the lane array.
  always_comb begin
    cur_data = '0;
    cur_ovf  = 1'b0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (idx_q == IDX_WIDTH'(i)) begin
        cur_data = lane_data[i];
        cur_ovf  = lane_ovf[i];
      end
    end
  end

  assign run  = (state_q == RUN);
  assign last = (idx_q == IDX_WIDTH'(NUM_INPUTS-1));

  assign idx_d = last ? '0 : idx_q + IDX_WIDTH'(1);
  assign err_d = err_q | cur_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      bus_q   <= '0;
      sum_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          bus_q   <= exp_bus;
          sum_q   <= exp_sum;
          idx_q   <= '0;
          err_q   <= 1'b0;
          state_q <= RUN;
        end
        RUN: if (out_ready) begin
          err_q <= err_d;
          idx_q <= idx_d;
          if (last) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = ~run;
  assign out_valid = run;
  assign busy      = run;
  assign out_index = idx_q;
  assign out_data  = run ? cur_data : '0;
  assign out_ovf   = run & cur_ovf;
  assign out_last  = run & last;
  assign out_err   = run & last & (err_q | cur_ovf);
endmodule

// File: tb/tb_exp_restore_serializer.sv
// Scoreboarded random/directed bench: accepted vectors push expected beats,
// an output monitor compares every valid cycle against the queue head.

module tb_exp_restore_serializer;
  localparam int N  = 10;
  localparam int EW = 9;
  localparam int MW = 8;
  localparam int IW = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [EW-1:0]     exp_sum = '0;
  logic [N*EW-1:0]   exp_bus = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [MW-1:0]     out_data;
  logic [IW-1:0]     out_index;
  logic              out_ovf, out_last, out_err, busy;

  typedef struct packed {
    logic [MW-1:0] data;
    logic [IW-1:0] idx;
    logic          ovf;
    logic          last;
    logic          err;
  } beat_t;

  beat_t q[$];
  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;
  int rdy_mode = 0;
  int rdy_ph = 0;

  exp_restore_serializer #(.NUM_INPUTS(N), .EXP_WIDTH(EW), .MANT_WIDTH(MW), .IDX_WIDTH(IW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .exp_sum(exp_sum), .exp_bus(exp_bus), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_index(out_index), .out_ovf(out_ovf), .out_last(out_last),
    .out_err(out_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: plain modular arithmetic over the whole vector.
  function automatic void push_vec(input logic [N*EW-1:0] bus, input logic [EW-1:0] sum);
    int s;
    bit any_ovf;
    beat_t b;
    any_ovf = 0;
    for (int i = 0; i < N; i++) begin
      s = (int'(bus[i*EW +: EW]) + int'(sum)) % 512;
      b.data = MW'(s % 256);
      b.idx  = IW'(i);
      b.ovf  = (s >= 256);
      any_ovf = any_ovf | b.ovf;
      b.last = (i == N-1);
      b.err  = (i == N-1) ? any_ovf : 1'b0;
      q.push_back(b);
    end
  endfunction

  always @(negedge clk)
    if (!rst && in_valid && in_ready) push_vec(exp_bus, exp_sum);

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL beat_unexpected: got index %0d expected no beat", out_index);
      end else begin
        check("beat", 32'({out_data, out_index, out_ovf, out_last, out_err}), 32'(q[0]));
        if (out_ready) begin
          void'(q.pop_front());
          hs_cnt++;
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: begin out_ready = (rdy_ph % 3 == 0); rdy_ph++; end
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic send(input logic [N*EW-1:0] bus, input logic [EW-1:0] sum);
    bit ok;
    @(posedge clk); #1;
    in_valid = 1'b1; exp_bus = bus; exp_sum = sum;
    ok = 0;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk);
      if (in_ready) ok = 1;
    end
    if (!ok) begin checks++; errors++; $display("FAIL accept_timeout: got no in_ready expected acceptance"); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp_bus = {$urandom, $urandom, $urandom};
    exp_sum = EW'($urandom);
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int c = 0; c < 400 && !ok; c++) begin
      @(negedge clk);
      if (q.size() == 0 && in_ready) ok = 1;
    end
    if (!ok) begin checks++; errors++; $display("FAIL drain_timeout: got %0d beats left expected 0", q.size()); end
    check("idle_out_valid", 32'(out_valid), 0);
    check("idle_busy", 32'(busy), 0);
    check("idle_data", 32'({out_data, out_index}), 0);
  endtask

  task automatic count_low(output int n);
    n = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (in_ready) break;
      n++;
    end
  endtask

  function automatic logic [N*EW-1:0] rand_bus();
    logic [N*EW-1:0] b;
    for (int i = 0; i < N; i++) b[i*EW +: EW] = EW'($urandom);
    return b;
  endfunction

  initial begin
    logic [N*EW-1:0] bus_a, bus_b;
    int n, h0;

    #12;
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_outs", 32'({out_valid, out_last, out_ovf, out_err, busy}), 0);
    check("rst_data", 32'({out_data, out_index}), 0);
    @(posedge clk); #1; rst = 1'b0;

    // Ramp: lane i = 10*i - 5, sum 5.
    for (int i = 0; i < N; i++) bus_a[i*EW +: EW] = EW'((10*i - 5 + 512) % 512);
    check("ramp_lane0", 32'(bus_a[EW-1:0]), 32'h1FB);
    send(bus_a, 5);
    count_low(n);
    check("in_ready_low_cycles", n, 10);
    drain();

    // Single overflowing lane.
    bus_b = '0; bus_b[3*EW +: EW] = 9'h0FF;
    send(bus_b, 1);
    drain();

    // Modular wrap.
    bus_a = rand_bus(); bus_a[0 +: EW] = 9'h100; bus_a[EW +: EW] = 9'h1FF;
    send(bus_a, 9'h100);
    drain();

    // Backpressure with an extra in_valid pulse mid-vector.
    rdy_mode = 1;
    h0 = hs_cnt;
    send(rand_bus(), EW'($urandom));
    repeat (3) @(posedge clk);
    #1; in_valid = 1'b1; exp_bus = rand_bus();
    @(posedge clk); #1; in_valid = 1'b0;
    drain();
    check("bp_handshakes", hs_cnt - h0, 10);
    rdy_mode = 0;

    // Back-to-back: A overflows, B clean; valid held across the boundary.
    @(posedge clk); #1;
    in_valid = 1'b1; exp_bus = bus_b; exp_sum = 1;
    for (int c = 0; c < 50; c++) begin @(negedge clk); if (in_ready) break; end
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) bus_a[i*EW +: EW] = EW'((10*i - 5 + 512) % 512);
    exp_bus = bus_a; exp_sum = 5;
    count_low(n);
    check("b2b_gap", n, 10);
    @(posedge clk); #1; in_valid = 1'b0;
    drain();

    // Random vectors under random backpressure.
    rdy_mode = 2;
    for (int v = 0; v < 8; v++) begin
      h0 = hs_cnt;
      send(rand_bus(), EW'($urandom));
      drain();
      check("rand_handshakes", hs_cnt - h0, 10);
    end
    rdy_mode = 0;

    // Reset in the middle of a vector.
    send(rand_bus(), EW'($urandom));
    n = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (out_valid && out_index == 4) begin n = 1; break; end
    end
    check("reached_index4", n, 1);
    #1; rst = 1'b1; #1;
    check("midrst_out_valid", 32'(out_valid), 0);
    check("midrst_ready_busy", 32'({in_ready, busy}), 32'b10);
    q.delete();
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("post_rst_idle", 32'({in_ready, busy, out_valid}), 32'b100);
    send(rand_bus(), EW'($urandom));
    drain();

    check("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
